fnn_result_unit: RTL
====================

# fnn_result_unit

Output-stage result unit of the FNN inference datapath, directly downstream of the layer-3 output registers. For each test sample it serially scans the 10 output-neuron values to find the predicted class and compares it with the sample label. It produces the `eq` flag that gates the correct-prediction accumulator. After the last sample it keeps running totals and computes integer accuracy in percent with a serial divider.

## Interface
Parameters:
- `N_OUT`, 10: number of output neurons / classes
- `DW`, 8: width of each output value, two's-complement signed
- `CW`, 10: width of the sample and correct counters (covers 750 samples)

Ports:
- `clk`, in, 1: clock
- `rst`, in, 1: reset, asynchronous, active-high
- `start`, in, 1: single-cycle pulse; captures `out_vec`, `label` and `last`
- `out_vec`, in, `N_OUT*DW`: neuron j occupies bits [j*DW +: DW]
- `label`, in, 4: true class, 0..9
- `last`, in, 1: this sample is the final one
- `busy`, out, 1: high in SCAN, CMP and DIV
- `pred`, out, 4: predicted class of the most recent sample
- `eq_valid`, out, 1: one-cycle pulse; `eq` is valid in that cycle
- `eq`, out, 1: `pred == label`; held until the next CMP
- `sample_cnt`, out, `CW`: number of samples evaluated
- `correct_cnt`, out, `CW`: number of samples with `eq == 1`
- `acc_pct`, out, 7: floor(`correct_cnt`*100 / `sample_cnt`); valid while `done` is high
- `done`, out, 1: level signal; stays high until `rst`

## Operation
- Reset value of every output is 0. The FSM resets to IDLE.
- States: IDLE, SCAN, CMP, DIV, DONE.
- IDLE: `start`=1 latches `out_vec`, `label` and `last` into internal registers.
  - Sets the running max to neuron 0 and the best index to 0, and clears the scan index to 1.
  - Next state is SCAN.
- SCAN: each cycle compares neuron[i] with the running max, using a signed compare.
  - A strictly greater value replaces the max and the best index, so ties resolve to the lowest index.
  - i increments each cycle. After i = N_OUT-1 the next state is CMP.
  - SCAN lasts N_OUT-1 cycles.
- CMP: `pred` ← best index, `eq` ← (best index == latched label), `eq_valid`=1, `sample_cnt` += 1, `correct_cnt` += `eq`.
  - Next state is DIV if the latched `last` is 1, otherwise IDLE.
- DIV: the dividend is `correct_cnt`*100, computed as a 17-bit product with shifts and adds (x64 + x32 + x4). The divisor is `sample_cnt`.
  - Restoring division, one quotient bit per cycle, MSB first, 17 cycles.
  - The quotient is at most 100. `acc_pct` takes the low 7 bits; the truncation is lossless.
  - `sample_cnt` is ≥ 1 by construction, so divide-by-zero cannot occur.
- DONE: `done`=1. `start` is ignored. Only `rst` leaves this state.
- `start` arriving in any state other than IDLE is ignored: it is not queued and does not disturb the active sample.
- Counters saturate at 2^CW-1. They do not wrap.
- `label` values above 9 are legal inputs and simply yield `eq`=0.
- Reset mid-operation (any state, including mid-DIV) aborts immediately and returns all outputs and counters to 0.

## Timing
- `start` is sampled at edge k, so IDLE→SCAN takes effect at k.
- SCAN occupies cycles k+1 .. k+N_OUT-1; CMP is cycle k+N_OUT.
- `eq_valid` is high for exactly one cycle, N_OUT cycles after the `start` edge (10 with default parameters).
- Counters show their updated value from edge k+N_OUT+1.
- `busy` is high from cycle k+1 through CMP and, if `last`, through DIV. It is low in IDLE and DONE.
- Back-to-back samples: the earliest accepted next `start` is the cycle after CMP. Minimum sample period is N_OUT+1 cycles.
- With `last`: DIV runs over cycles k+N_OUT+1 .. k+N_OUT+17. `done` and `acc_pct` are valid from edge k+N_OUT+18 onward.
- The upstream controller must hold `label` stable only in the `start` cycle, because the value is latched.

## Structure
- Shared package `fnn_pkg` holds:
  - `N_OUT`, `DW`, `CW`
  - `CLASS_W` = 4
  - the result FSM state enum
  - `PCT_DIV_W` = 17
- Sub-module `fnn_seq_div` is a generic restoring divider.
  - Ports: clk, rst, `go`, dividend, divisor, quotient, `q_valid`.
  - Latency is fixed at the dividend width in cycles.
  - It is instantiated once. Its `go` is driven on CMP→DIV.

## Test plan
- All ten outputs = 8'sd5, label 0 → `pred`=0 and `eq`=1 (tie resolves to lowest index); `eq_valid` pulses 10 cycles after `start`.
- Outputs all −3 except neuron 9 = −1, label 9 → `pred`=9 and `eq`=1. Repeat with neuron 7 = 127 and neuron 2 = −128 → `pred`=7 (checks signed compare).
- 750 samples, 600 correct, `last` on the final one → `correct_cnt`=600, `sample_cnt`=750, `acc_pct`=80; `done` rises 28 cycles after the final `start`.
- 3 samples, 2 correct → `acc_pct`=66 (truncation). 1 sample, 1 correct → `acc_pct`=100.
- Pulse `start` during SCAN and again during DIV → no effect; counts unchanged and only one `eq_valid` per accepted sample. `start` while `done`=1 → ignored.
- Assert `rst` mid-SCAN and mid-DIV → all outputs read 0 on the next cycle; a fresh sample after reset yields `sample_cnt`=1.

Source files
------------

// File: rtl/fnn_pkg.sv
// Shared constants and types for the FNN output-stage result unit.
package fnn_pkg;

    localparam int N_OUT     = 10;
    localparam int DW        = 8;
    localparam int CW        = 10;
    localparam int CLASS_W   = 4;
    localparam int PCT_DIV_W = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_CMP,
        S_DIV,
        S_DONE
    } res_state_e;

endpackage

// File: rtl/fnn_seq_div.sv
// Generic restoring divider: one quotient bit per cycle, MSB first.
// The first step happens on the go edge, so q_valid pulses NW cycles after go.
module fnn_seq_div #(
    parameter int NW  = 17,
    parameter int DVW = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [NW-1:0]  dividend,
    input  logic [DVW-1:0] divisor,
    output logic [NW-1:0]  quotient,
    output logic           q_valid
);

    localparam int CNT_W = $clog2(NW + 1);

    logic [DVW-1:0] rem_q, dsr_q;
    logic [NW-1:0]  quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic           run_q;

    logic [DVW-1:0] rem_in, dsr_in, rem_nxt;
    logic [NW-1:0]  quo_in, quo_nxt;
    logic [DVW:0]   shifted;
    logic [DVW+1:0] diff;
    logic           fits;
    logic           unused_diff;

    // On go the step works straight from the input operands.
    assign rem_in  = go ? '0 : rem_q;
    assign quo_in  = go ? dividend : quo_q;
    assign dsr_in  = go ? divisor : dsr_q;

    assign shifted = {rem_in, quo_in[NW-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dsr_in};
    assign fits    = ~diff[DVW+1];
    assign rem_nxt = fits ? diff[DVW-1:0] : shifted[DVW-1:0];
    assign quo_nxt = {quo_in[NW-2:0], fits};
    assign unused_diff = diff[DVW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            if (go) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                dsr_q <= dsr_in;
                cnt_q <= CNT_W'(NW - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q   <= 1'b0;
                    q_valid <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/fnn_result_unit.sv
// Output-stage result unit: serial argmax over the output neurons, label compare,
// saturating sample/correct counters and a final accuracy-percent division.
module fnn_result_unit #(
    parameter int N_OUT = fnn_pkg::N_OUT,
    parameter int DW    = fnn_pkg::DW,
    parameter int CW    = fnn_pkg::CW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_OUT*DW-1:0]         out_vec,
    input  logic [fnn_pkg::CLASS_W-1:0] label,
    input  logic                        last,
    output logic                        busy,
    output logic [fnn_pkg::CLASS_W-1:0] pred,
    output logic                        eq_valid,
    output logic                        eq,
    output logic [CW-1:0]               sample_cnt,
    output logic [CW-1:0]               correct_cnt,
    output logic [6:0]                  acc_pct,
    output logic                        done
);

    import fnn_pkg::*;

    localparam int IW = CLASS_W;
    localparam logic [CW-1:0] CNT_MAX = '1;

    res_state_e state_q, state_d;

    logic [N_OUT*DW-1:0]  vec_q;
    logic [IW-1:0]        label_q;
    logic                 last_q;
    logic signed [DW-1:0] max_q, max_nxt, cur;
    logic [IW-1:0]        best_q, best_nxt, idx_q;
    logic signed [DW-1:0] nv [N_OUT];
    logic                 scan_end;

    logic [CW-1:0]        sample_nxt, correct_nxt;
    logic [PCT_DIV_W-1:0] c_ext, div_dividend, div_quot;
    logic                 div_go, div_qv;
    logic                 unused_quot_hi;

    for (genvar j = 0; j < N_OUT; j++) begin : g_unpack
        assign nv[j] = vec_q[j*DW +: DW];
    end

    // Strictly-greater replacement keeps the lowest index on ties.
    assign cur      = nv[idx_q];
    assign max_nxt  = (cur > max_q) ? cur : max_q;
    assign best_nxt = (cur > max_q) ? idx_q : best_q;
    assign scan_end = (state_q == S_SCAN) && (idx_q == IW'(N_OUT - 1));

    assign sample_nxt  = (sample_cnt == CNT_MAX) ? sample_cnt : sample_cnt + CW'(1);
    assign correct_nxt = (eq && correct_cnt != CNT_MAX) ? correct_cnt + CW'(1) : correct_cnt;

    // Dividend uses the post-increment counts since the divider loads on the CMP edge.
    assign c_ext        = PCT_DIV_W'(correct_nxt);
    assign div_dividend = (c_ext << 6) + (c_ext << 5) + (c_ext << 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        div_go  = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_SCAN;
            S_SCAN: if (scan_end) state_d = S_CMP;
            S_CMP: begin
                div_go  = last_q;
                state_d = last_q ? S_DIV : S_IDLE;
            end
            S_DIV:  if (div_qv) state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q       <= '0;
            label_q     <= '0;
            last_q      <= 1'b0;
            max_q       <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            pred        <= '0;
            eq          <= 1'b0;
            eq_valid    <= 1'b0;
            sample_cnt  <= '0;
            correct_cnt <= '0;
            acc_pct     <= '0;
        end else begin
            eq_valid <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    vec_q   <= out_vec;
                    label_q <= label;
                    last_q  <= last;
                    max_q   <= out_vec[DW-1:0];
                    best_q  <= '0;
                    idx_q   <= IW'(1);
                end
                S_SCAN: begin
                    max_q  <= max_nxt;
                    best_q <= best_nxt;
                    idx_q  <= idx_q + IW'(1);
                    // Result is registered as SCAN ends so it is valid throughout CMP.
                    if (scan_end) begin
                        pred     <= best_nxt;
                        eq       <= (best_nxt == label_q);
                        eq_valid <= 1'b1;
                    end
                end
                S_CMP: begin
                    sample_cnt  <= sample_nxt;
                    correct_cnt <= correct_nxt;
                end
                S_DIV: if (div_qv) acc_pct <= div_quot[6:0];
                default: ;
            endcase
        end
    end

    // Quotient never exceeds 100, so the upper bits are always zero.
    assign unused_quot_hi = ^div_quot[PCT_DIV_W-1:7];

    fnn_seq_div #(
        .NW  (PCT_DIV_W),
        .DVW (CW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (div_go),
        .dividend (div_dividend),
        .divisor  (sample_nxt),
        .quotient (div_quot),
        .q_valid  (div_qv)
    );

    assign busy = (state_q == S_SCAN) || (state_q == S_CMP) || (state_q == S_DIV);
    assign done = (state_q == S_DONE);

endmodule
